// File: rtl/can_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_pkg
// Purpose  : Shared types and constants for the CAN transmit bit sequencer.
//            Holds the sequencer state encoding, the bus level names and the
//            sizes of the unstuffed frame tail.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package can_tx_pkg;

  // Sequencer states. The encoding width is fixed at 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STUFF = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIXED = 3'd4
  } tx_state_e;

  // Bus levels: the idle / recessive level is logic 1.
  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  // Unstuffed tail following the CRC sequence.
  localparam int CRC_DELIM = 1;
  localparam int ACK       = 2;
  localparam int EOF       = 7;
  localparam int TAIL_BITS = CRC_DELIM + ACK + EOF;

endpackage
`default_nettype wire

// File: rtl/can_tx_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_bit_sequencer
// Purpose  : Frame-level CAN transmit controller. Walks a bit-addressable
//            frame buffer, feeding the stuffed region (SOF..CRC) to the bit
//            stuffer one bit time at a time and routing the stuffer output
//            to the line, then drives the unstuffed tail straight from the
//            buffer. Owns frame start, completion and abort sequencing.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            bit_start             - one-clock pulse per nominal bit time
//            frame_req             - level request to send the buffered frame
//            stuff_len, total_len  - stuffed / total bit counts (at accept)
//            abort                 - arbitration loss / error
//            frame_ack/done/aborted- one-clock status pulses
//            busy                  - frame in progress
//            rd_addr, rd_bit       - frame buffer bit read port
//            stf_flush/data/valid  - to bit stuffer
//            stf_hold/pending/out/out_valid - from bit stuffer
//            tx_bit                - line bit to transceiver (1 = recessive)
// Revision : 1.0 - initial release
// ============================================================================
module can_tx_bit_sequencer
  import can_tx_pkg::*;
#(
  parameter int MAX_BITS = 160,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bit_start,
  input  logic          frame_req,
  input  logic [AW:0]   stuff_len,
  input  logic [AW:0]   total_len,
  input  logic          abort,
  output logic          frame_ack,
  output logic          frame_done,
  output logic          frame_aborted,
  output logic          busy,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_bit,
  output logic          stf_flush,
  output logic          stf_data,
  output logic          stf_valid,
  input  logic          stf_hold,
  input  logic          stf_pending,
  input  logic          stf_out,
  input  logic          stf_out_valid,
  output logic          tx_bit
);

  localparam int            LW         = AW + 1;
  localparam logic [AW:0]   c_max_bits = LW'(MAX_BITS);
  localparam logic [AW:0]   c_len_one  = LW'(1);
  localparam logic [AW-1:0] c_addr_one = AW'(1);
  localparam logic [AW:0]   c_len_zero = '0;

  tx_state_e   r_state;
  logic [AW:0] r_slen;
  logic [AW:0] r_tlen;

  logic [AW:0] w_tlen_clamp;
  logic [AW:0] w_slen_clamp;
  logic [AW:0] w_addr_ext;
  logic        w_stuff_last;
  logic        w_fixed_last;

  // The stuffed length can never exceed the (already clamped) total length,
  // which keeps rd_addr inside the buffer in every state.
  assign w_tlen_clamp = (total_len > c_max_bits) ? c_max_bits : total_len;
  assign w_slen_clamp = (stuff_len > w_tlen_clamp) ? w_tlen_clamp : stuff_len;

  assign w_addr_ext   = {1'b0, rd_addr};
  assign w_stuff_last = (w_addr_ext == (r_slen - c_len_one));
  assign w_fixed_last = (w_addr_ext == (r_tlen - c_len_one));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_slen        <= '0;
      r_tlen        <= '0;
      rd_addr       <= '0;
      tx_bit        <= RECESSIVE;
      stf_data      <= RECESSIVE;
      stf_valid     <= 1'b0;
      stf_flush     <= 1'b0;
      frame_ack     <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_ack     <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
      stf_flush     <= 1'b0;

      if ((r_state != ST_IDLE) && abort) begin
        // Abort outranks everything, including a last bit in this clock.
        r_state       <= ST_IDLE;
        tx_bit        <= RECESSIVE;
        stf_data      <= RECESSIVE;
        stf_valid     <= 1'b0;
        stf_flush     <= 1'b1;
        frame_aborted <= 1'b1;
        busy          <= 1'b0;
        rd_addr       <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bit_start) begin
              tx_bit <= RECESSIVE;
            end
            if (frame_req) begin
              frame_ack <= 1'b1;
              stf_flush <= 1'b1;
              busy      <= 1'b1;
              rd_addr   <= '0;
              r_tlen    <= w_tlen_clamp;
              r_slen    <= w_slen_clamp;
              r_state   <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            if (r_tlen == c_len_zero) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              r_state    <= ST_IDLE;
            end else if (r_slen == c_len_zero) begin
              r_state <= ST_FIXED;
            end else begin
              stf_data  <= rd_bit;
              stf_valid <= 1'b1;
              r_state   <= ST_STUFF;
            end
          end

          ST_STUFF: begin
            if (stf_out_valid) begin
              tx_bit <= stf_out;
            end
            if (bit_start && !stf_hold) begin
              if (w_stuff_last) begin
                stf_valid <= 1'b0;
                stf_data  <= RECESSIVE;
                r_state   <= ST_DRAIN;
              end else begin
                rd_addr <= rd_addr + c_addr_one;
              end
            end else begin
              // Refresh from the buffer; after an address step this picks
              // up the new bit one clock later, and is a no-op while held.
              stf_data <= rd_bit;
            end
          end

          ST_DRAIN: begin
            // The stuffer may emit its final bit on the same bit time that
            // reports nothing further pending, so capture before leaving.
            if (stf_out_valid) begin
              tx_bit <= stf_out;
            end
            if (bit_start && !stf_pending) begin
              if (r_slen == r_tlen) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                r_state    <= ST_IDLE;
              end else begin
                rd_addr <= r_slen[AW-1:0];
                r_state <= ST_FIXED;
              end
            end
          end

          ST_FIXED: begin
            if (bit_start) begin
              tx_bit <= rd_bit;
              if (w_fixed_last) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                r_state    <= ST_IDLE;
              end else begin
                rd_addr <= rd_addr + c_addr_one;
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
